// File: rtl/i2s_pkg.sv
// i2s_pkg: shared types and constants for the I2S receiver.
//   i2s_rx_state_t : receiver framing state
//   I2S_MAX_SLOT   : longest legal slot in bits
//   I2S_CNT_W      : width of the per-slot bit counter
package i2s_pkg;

    typedef enum logic [1:0] {
        SEARCH,
        RX_LEFT,
        RX_RIGHT
    } i2s_rx_state_t;

    localparam int unsigned I2S_MAX_SLOT = 32;
    localparam int unsigned I2S_CNT_W    = 6;

endpackage

// File: rtl/i2s_sync.sv
// i2s_sync: brings the asynchronous I2S pins into the system clock domain.
// Ports:
//   i_clk, i_reset          : system clock, synchronous active-high reset
//   i_sclk, i_lrclk, i_sdata: raw I2S pins
//   o_rise                  : one-cycle pulse per BCK rising edge
//   o_ws, o_d               : word select / data coherent with o_rise
module i2s_sync (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_sclk,
    input  logic i_lrclk,
    input  logic i_sdata,
    output logic o_rise,
    output logic o_ws,
    output logic o_d
);

    logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic r_lr_meta, r_lr_sync;
    logic r_sd_meta, r_sd_sync;
    logic r_rise, r_ws, r_d;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_lr_meta   <= 1'b0;
            r_lr_sync   <= 1'b0;
            r_sd_meta   <= 1'b0;
            r_sd_sync   <= 1'b0;
            r_rise      <= 1'b0;
            r_ws        <= 1'b0;
            r_d         <= 1'b0;
        end else begin
            r_sclk_meta <= i_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_lr_meta   <= i_lrclk;
            r_lr_sync   <= r_lr_meta;
            r_sd_meta   <= i_sdata;
            r_sd_sync   <= r_sd_meta;
            // Edge register; ws/d take the same extra stage so they line up with it.
            r_rise      <= r_sclk_sync & ~r_sclk_prev;
            r_ws        <= r_lr_sync;
            r_d         <= r_sd_sync;
        end
    end

    assign o_rise = r_rise;
    assign o_ws   = r_ws;
    assign o_d    = r_d;

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S receiver. Deserialises MSB-first left/right slots (DATA_WIDTH..32 bits)
// into DATA_WIDTH-bit samples, with lock tracking and loss-of-signal timeout.
// Ports:
//   clk_sys, reset            : system clock, synchronous active-high reset
//   sclk, lrclk, sdata        : asynchronous I2S inputs
//   left_chan, right_chan     : last published stereo pair
//   sample_valid              : one-cycle pulse when a pair is published
//   locked                    : LOCK_FRAMES consecutive good pairs seen
//   frame_err                 : one-cycle pulse on an illegal slot length
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned TIMEOUT     = 4096,
    parameter int unsigned LOCK_FRAMES = 4
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  lrclk,
    input  logic                  sdata,
    output logic [DATA_WIDTH-1:0] left_chan,
    output logic [DATA_WIDTH-1:0] right_chan,
    output logic                  sample_valid,
    output logic                  locked,
    output logic                  frame_err
);

    localparam int unsigned LEN_W  = I2S_CNT_W + 1;
    localparam int unsigned LOCK_W = $clog2(LOCK_FRAMES + 1);
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [I2S_CNT_W-1:0] CNT_DW    = I2S_CNT_W'(DATA_WIDTH);
    localparam logic [I2S_CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [LEN_W-1:0]     LEN_MIN   = LEN_W'(DATA_WIDTH);
    localparam logic [LEN_W-1:0]     LEN_MAX   = LEN_W'(I2S_MAX_SLOT);
    localparam logic [LOCK_W-1:0]    LOCK_MAX  = LOCK_W'(LOCK_FRAMES);
    localparam logic [IDLE_W-1:0]    IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    logic w_rise, w_ws, w_d;

    i2s_sync u_sync (
        .i_clk   (clk_sys),
        .i_reset (reset),
        .i_sclk  (sclk),
        .i_lrclk (lrclk),
        .i_sdata (sdata),
        .o_rise  (w_rise),
        .o_ws    (w_ws),
        .o_d     (w_d)
    );

    i2s_rx_state_t         r_state;
    logic                  r_ws_prev;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [I2S_CNT_W-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_left_hold;
    logic                  r_left_ok;
    logic [LOCK_W-1:0]     r_lock_cnt;
    logic [IDLE_W-1:0]     r_idle_cnt;
    logic [DATA_WIDTH-1:0] r_left_chan, r_right_chan;
    logic                  r_sample_valid, r_locked, r_frame_err;

    logic                  w_change;
    logic [LEN_W-1:0]      w_len;
    logic                  w_legal;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_timeout;
    logic [LOCK_W-1:0]     w_lock_next;

    always_comb begin
        w_change = w_rise && (w_ws != r_ws_prev);
        // The change-carrying rise holds the slot's final bit, hence count + 1.
        w_len    = {1'b0, r_cnt} + LEN_W'(1);
        w_legal  = (w_len >= LEN_MIN) && (w_len <= LEN_MAX);
        // Below DATA_WIDTH bits the final bit still belongs in the word; beyond, truncate.
        w_word   = (r_cnt < CNT_DW) ? {r_shift[DATA_WIDTH-2:0], w_d} : r_shift;
        // A rise in the same cycle beats the timeout.
        w_timeout   = !w_rise && (r_idle_cnt == IDLE_LAST);
        w_lock_next = (r_lock_cnt == LOCK_MAX) ? LOCK_MAX : r_lock_cnt + LOCK_W'(1);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state        <= SEARCH;
            r_ws_prev      <= 1'b0;
            r_shift        <= '0;
            r_cnt          <= '0;
            r_left_hold    <= '0;
            r_left_ok      <= 1'b0;
            r_lock_cnt     <= '0;
            r_idle_cnt     <= '0;
            r_left_chan    <= '0;
            r_right_chan   <= '0;
            r_sample_valid <= 1'b0;
            r_locked       <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_frame_err    <= 1'b0;

            if (w_rise) begin
                r_idle_cnt <= '0;
            end else if (!w_timeout) begin
                r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
            end

            if (w_timeout) begin
                r_state      <= SEARCH;
                r_left_chan  <= '0;
                r_right_chan <= '0;
                r_lock_cnt   <= '0;
                r_locked     <= 1'b0;
                r_left_ok    <= 1'b0;
                r_cnt        <= '0;
                r_shift      <= '0;
            end else if (w_rise) begin
                r_ws_prev <= w_ws;
                if (!w_change) begin
                    if (r_cnt < CNT_DW) begin
                        r_shift <= {r_shift[DATA_WIDTH-2:0], w_d};
                    end
                    if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + I2S_CNT_W'(1);
                    end
                end else begin
                    r_cnt   <= '0;
                    r_shift <= '0;
                    unique case (r_state)
                        SEARCH: begin
                            // Only a right->left boundary gives a known frame start.
                            if (!w_ws) begin
                                r_state <= RX_LEFT;
                            end
                        end
                        RX_LEFT: begin
                            r_left_hold <= w_word;
                            r_left_ok   <= w_legal;
                            if (!w_legal) begin
                                r_frame_err <= 1'b1;
                                r_lock_cnt  <= '0;
                                r_locked    <= 1'b0;
                            end
                            r_state <= RX_RIGHT;
                        end
                        RX_RIGHT: begin
                            if (r_left_ok && w_legal) begin
                                r_left_chan    <= r_left_hold;
                                r_right_chan   <= w_word;
                                r_sample_valid <= 1'b1;
                                r_lock_cnt     <= w_lock_next;
                                r_locked       <= (w_lock_next == LOCK_MAX);
                            end else begin
                                // A bad left slot already flagged this pair.
                                r_frame_err <= r_left_ok;
                                r_lock_cnt  <= '0;
                                r_locked    <= 1'b0;
                            end
                            r_state <= RX_LEFT;
                        end
                        default: r_state <= SEARCH;
                    endcase
                end
            end
        end
    end

    assign left_chan    = r_left_chan;
    assign right_chan   = r_right_chan;
    assign sample_valid = r_sample_valid;
    assign locked       = r_locked;
    assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: randomized scoreboard bench for i2s_rx. The stimulus side builds I2S frames
// from slot lengths and data, predicts published pairs / frame errors with a frame-level
// model, and queues them; a monitor on the opposite clock edge pops and compares.
module tb_i2s_rx;

    localparam int unsigned DW = 16;
    localparam int unsigned TO = 4096;
    localparam int unsigned LF = 4;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b1;
    logic          sclk    = 1'b0;
    logic          lrclk   = 1'b0;
    logic          sdata   = 1'b0;
    logic [DW-1:0] left_chan, right_chan;
    logic          sample_valid, locked, frame_err;

    i2s_rx #(
        .DATA_WIDTH  (DW),
        .TIMEOUT     (TO),
        .LOCK_FRAMES (LF)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .left_chan    (left_chan),
        .right_chan   (right_chan),
        .sample_valid (sample_valid),
        .locked       (locked),
        .frame_err    (frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        lk;
        int          t;
    } pair_t;

    pair_t exp_q[$];
    int    err_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    int    half     = 4;
    bit    acquired = 0;
    int    lock_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic check_lat(input string name, input int lat);
        n_checks++;
        if (lat >= 4 && lat <= 5) n_pass++;
        else $display("FAIL %s: got %0d cycles expected 4..5", name, lat);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One BCK period: data/ws set during the low phase, sampled at the rise.
    task automatic bck_bit(input logic ws, input logic d);
        lrclk = ws;
        sdata = d;
        repeat (half) tick();
        sclk = 1'b1;
        repeat (half) tick();
        sclk = 1'b0;
    endtask

    function automatic bit legal(input int len);
        return (len >= 16) && (len <= 32);
    endfunction

    function automatic logic [15:0] top16(input logic [63:0] data, input int len);
        return 16'(data >> (len - 16));
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_left"}, 32'(left_chan), 32'h0);
        check({tag, "_right"}, 32'(right_chan), 32'h0);
        check({tag, "_locked"}, 32'(locked), 32'h0);
    endtask

    // Model: a pair is published only if a right->left boundary was seen beforehand
    // (no reset/timeout since) and both slot lengths are legal.
    task automatic send_frame(input int ll, input int rl, input logic [63:0] ld,
                              input logic [63:0] rd, input bit rst_mid);
        bit acq;
        bit lok;
        bit rok;
        acq = acquired;
        lok = legal(ll);
        rok = legal(rl);
        for (int i = 0; i < ll - 1; i++) bck_bit(1'b0, ld[ll-1-i]);
        // Expected event time is the cycle on which the change-carrying rise is driven.
        if (acq && !lok) err_q.push_back(cyc + half);
        bck_bit(1'b1, ld[0]);
        for (int i = 0; i < rl - 1; i++) begin
            if (rst_mid && i == rl / 2) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check_zero("mid_reset");
                check("mid_reset_valid", 32'(sample_valid), 32'h0);
                acq      = 0;
                acquired = 0;
                lock_cnt = 0;
            end
            bck_bit(1'b1, rd[rl-1-i]);
        end
        if (acq) begin
            if (lok && rok) begin
                lock_cnt = (lock_cnt < LF) ? lock_cnt + 1 : LF;
                exp_q.push_back('{top16(ld, ll), top16(rd, rl), lock_cnt >= LF, cyc + half});
            end else begin
                lock_cnt = 0;
                if (lok) err_q.push_back(cyc + half);
            end
        end
        bck_bit(1'b0, rd[0]);
        acquired = 1;
    endtask

    task automatic rand_frame(input int len);
        send_frame(len, len, 64'($urandom), 64'($urandom), 1'b0);
    endtask

    task automatic settle(input string tag);
        repeat (10) tick();
        check({tag, "_locked"}, 32'(locked), 32'(lock_cnt >= LF));
    endtask

    always @(negedge clk_sys) begin
        pair_t e;
        int    t;
        if (sample_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: got sample_valid=1 expected 0");
            end else begin
                e = exp_q.pop_front();
                check("left_chan", 32'(left_chan), 32'(e.l));
                check("right_chan", 32'(right_chan), 32'(e.r));
                check("locked_at_valid", 32'(locked), 32'(e.lk));
                check_lat("valid_latency", cyc - e.t);
            end
        end
        if (frame_err) begin
            if (err_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_frame_err: got frame_err=1 expected 0");
            end else begin
                t = err_q.pop_front();
                check_lat("err_latency", cyc - t);
                check("locked_at_err", 32'(locked), 32'h0);
            end
        end
    end

    initial begin
        repeat (5) tick();
        check_zero("reset");
        check("reset_valid", 32'(sample_valid), 32'h0);
        check("reset_err", 32'(frame_err), 32'h0);
        reset = 1'b0;
        tick();

        // 16-bit slots at clk/8: first pair discarded, lock on 4th published pair.
        half = 4;
        for (int k = 0; k < 6; k++) send_frame(16, 16, 64'h1234, 64'hABCD, 1'b0);
        settle("t1");

        // 32-bit slots, truncated to the top 16 bits.
        for (int k = 0; k < 3; k++) send_frame(32, 32, 64'h8001_FFFF, 64'h7FFE_0000, 1'b0);
        settle("t2");

        // Short left slot: one error, pair dropped, lock lost then regained.
        send_frame(12, 16, 64'($urandom), 64'($urandom), 1'b0);
        settle("t3_err");
        for (int k = 0; k < 4; k++) rand_frame(16);
        settle("t3_relock");
        // Over-long right slot.
        send_frame(16, 40, 64'($urandom), 64'($urandom), 1'b0);
        rand_frame(16);
        settle("t3_right");

        // Loss of signal while locked.
        for (int k = 0; k < 4; k++) rand_frame(16);
        settle("t4_pre");
        repeat (TO + 100) tick();
        check_zero("timeout");
        acquired = 0;
        lock_cnt = 0;
        for (int k = 0; k < 3; k++) rand_frame(16);
        settle("t4_resume");

        // Reset in the middle of a right slot.
        for (int k = 0; k < 4; k++) rand_frame(16);
        send_frame(16, 16, 64'($urandom), 64'($urandom), 1'b1);
        for (int k = 0; k < 2; k++) rand_frame(16);
        settle("t5");

        // 24-bit random slots at clk/6.
        half = 3;
        for (int k = 0; k < 12; k++) rand_frame(24);
        settle("t6");

        repeat (20) tick();
        check("pending_pairs", 32'(exp_q.size()), 32'h0);
        check("pending_errs", 32'(err_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
